// File: rtl/dpll_pkg.sv
// Shared constants for the DPLL acquisition/tracking sequencer.
package dpll_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_ACQ   = 3'd2;
  localparam logic [2:0] ST_TRK   = 3'd3;

  localparam logic [7:0] MULT_N_DEF = 8'd32;
  localparam logic [7:0] H_DEF      = 8'd16;
  localparam logic [3:0] ACQ_K_DEF  = 4'd3;
  localparam logic [3:0] TRK_K_DEF  = 4'd6;

  typedef struct packed {
    logic [7:0] mult_n;
    logic [7:0] h;
  } dpll_cfg_t;

  // A divider of 0 would stall the loop; treat it as divide-by-1.
  function automatic logic [7:0] nz_div(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/dpll_event_window.sv
// Carry/borrow edge counting over fixed windows; reports the count at window end.
module dpll_event_window #(
  parameter int WIN_LEN = 4096
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic       carry_i,
  input  logic       borrow_i,
  output logic       win_end_o,
  output logic [7:0] win_count_o,
  output logic [7:0] win_events_o
);

  localparam int CW = $clog2(WIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  logic          carry_q, borrow_q;
  logic [CW-1:0] win_cnt_q;
  logic [7:0]    evt_q, win_events_q;
  logic [1:0]    inc;
  logic [8:0]    sum;

  // win_count_o already includes any edge arriving this cycle.
  always_comb begin
    inc         = {1'b0, carry_i & ~carry_q} + {1'b0, borrow_i & ~borrow_q};
    sum         = {1'b0, evt_q} + {7'd0, inc};
    win_count_o = sum[8] ? 8'hFF : sum[7:0];
    win_end_o   = run_i && (win_cnt_q == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      win_cnt_q    <= '0;
      evt_q        <= 8'd0;
      win_events_q <= 8'd0;
    end else begin
      carry_q  <= carry_i;
      borrow_q <= borrow_i;
      if (win_end_o) win_events_q <= win_count_o;
      if (clear_i) begin
        win_cnt_q <= '0;
        evt_q     <= 8'd0;
      end else if (run_i) begin
        if (win_end_o) begin
          win_cnt_q <= '0;
          evt_q     <= 8'd0;
        end else begin
          win_cnt_q <= win_cnt_q + 1'b1;
          evt_q     <= win_count_o;
        end
      end
    end
  end

  assign win_events_o = win_events_q;

endmodule

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop sequencer: config latch, loop flush, acquisition/tracking bandwidth and lock detect.
// state | meaning
// IDLE  | hold loop in reset, wait for start
// FLUSH | pulse loop_reset for FLUSH_LEN cycles with new config
// ACQ   | wide bandwidth, counting quiet windows toward lock
// TRK   | narrow bandwidth, locked; noisy window drops back to ACQ
module dpll_loop_ctrl
  import dpll_pkg::*;
#(
  parameter int         WIN_LEN    = 4096,
  parameter logic [3:0] ACQ_K      = ACQ_K_DEF,
  parameter logic [3:0] TRK_K      = TRK_K_DEF,
  parameter int         LOCK_THR   = 4,
  parameter int         LOCK_WINS  = 4,
  parameter int         UNLOCK_THR = 16,
  parameter int         FLUSH_LEN  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] cfg_mult_n_i,
  input  logic [7:0] cfg_h_i,
  input  logic       dlf_carry_i,
  input  logic       dlf_borrow_i,
  output logic [3:0] k_mode_o,
  output logic [7:0] mult_n_o,
  output logic [7:0] h_div_o,
  output logic       loop_reset_o,
  output logic       locked_o,
  output logic [2:0] state_o,
  output logic [7:0] win_events_o
);

  localparam int         FW          = $clog2(FLUSH_LEN + 1);
  localparam logic [7:0] LOCK_THR_W  = 8'(LOCK_THR);
  localparam logic [7:0] LOCK_WINS_W = 8'(LOCK_WINS);
  localparam logic [7:0] UNLK_THR_W  = 8'(UNLOCK_THR);

  logic [2:0]    state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [7:0]    quiet_q, quiet_d;
  dpll_cfg_t     cfg_q, cfg_d;
  logic [3:0]    k_mode_q;
  logic          locked_q, lrst_q;
  logic          run, accept, clear, win_end;
  logic [7:0]    win_count;

  dpll_event_window #(.WIN_LEN(WIN_LEN)) u_win (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear),
    .run_i        (run),
    .carry_i      (dlf_carry_i),
    .borrow_i     (dlf_borrow_i),
    .win_end_o    (win_end),
    .win_count_o  (win_count),
    .win_events_o (win_events_o)
  );

  // Restart is accepted everywhere except FLUSH and overrides window evaluation.
  always_comb begin
    run     = (state_q == ST_ACQ) || (state_q == ST_TRK);
    accept  = start_i && ((state_q == ST_IDLE) || run);
    state_d = state_q;
    flush_d = flush_q;
    quiet_d = quiet_q;
    cfg_d   = cfg_q;
    if (accept) begin
      cfg_d.mult_n = nz_div(cfg_mult_n_i);
      cfg_d.h      = nz_div(cfg_h_i);
      state_d      = ST_FLUSH;
      flush_d      = FW'(FLUSH_LEN - 1);
      quiet_d      = 8'd0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (flush_q == '0) state_d = ST_ACQ;
          else               flush_d = flush_q - 1'b1;
        end
        ST_ACQ: begin
          if (win_end) begin
            if (win_count <= LOCK_THR_W) begin
              if (quiet_q + 8'd1 == LOCK_WINS_W) begin
                state_d = ST_TRK;
                quiet_d = 8'd0;
              end else begin
                quiet_d = quiet_q + 8'd1;
              end
            end else begin
              quiet_d = 8'd0;
            end
          end
        end
        ST_TRK: begin
          if (win_end && (win_count > UNLK_THR_W)) state_d = ST_ACQ;
        end
        default: ;
      endcase
    end
    clear = ((state_d == ST_ACQ) || (state_d == ST_TRK)) && (state_d != state_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      flush_q  <= '0;
      quiet_q  <= 8'd0;
      cfg_q    <= '{mult_n: MULT_N_DEF, h: H_DEF};
      k_mode_q <= ACQ_K;
      locked_q <= 1'b0;
      lrst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      quiet_q  <= quiet_d;
      cfg_q    <= cfg_d;
      k_mode_q <= (state_d == ST_TRK) ? TRK_K : ACQ_K;
      locked_q <= (state_d == ST_TRK);
      lrst_q   <= (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    end
  end

  assign k_mode_o     = k_mode_q;
  assign mult_n_o     = cfg_q.mult_n;
  assign h_div_o      = cfg_q.h;
  assign loop_reset_o = lrst_q;
  assign locked_o     = locked_q;
  assign state_o      = state_q;

endmodule
